// File: rtl/pipe_adder_pkg.sv
// Shared constants and slice-index helpers for the pipelined ripple-carry adder.
package pipe_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

  function automatic int unsigned slice_hi(input int unsigned k, input int unsigned w);
    return (k + 1) * w - 1;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder built from per-bit xor/and/or cells.
module rca_slice #(
  parameter int unsigned W = 4
) (
  output logic         co,
  output logic [W-1:0] sum,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
  end

  assign co = c[W];

endmodule

// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: one W-bit slice per stage, valid/ready
// handshake with back-pressure and bubble collapsing.
module pipe_ripple_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ovf
);

  localparam int unsigned W    = N / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if ((N % STAGES) != 0) begin : g_bad_params
    $error("pipe_ripple_adder: N must be a multiple of STAGES");
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [N-1:0]      sum_q [STAGES];
  logic [N-1:0]      sum_d [STAGES];
  logic [N-1:0]      a_q   [STAGES];
  logic [N-1:0]      a_d   [STAGES];
  logic [N-1:0]      b_q   [STAGES];
  logic [N-1:0]      b_d   [STAGES];
  logic              ovf_q, ovf_d;

  logic [STAGES-1:0] load_c, drain_c;
  logic [W-1:0]      sl_a   [STAGES];
  logic [W-1:0]      sl_b   [STAGES];
  logic [W-1:0]      sl_sum [STAGES];
  logic [STAGES-1:0] sl_ci, sl_co;
  logic [N-1:0]      b_in_c;
  logic              cin0_c;

  // Subtraction is A + ~B + 1; the incoming ci is ignored in that mode.
  assign b_in_c = (sub == MODE_SUB) ? ~a1 : a1;
  assign cin0_c = (sub == MODE_SUB) ? 1'b1 : ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = slice_lo(k, W);
    if (k == 0) begin : g_first
      assign sl_a[k]  = a0[LO +: W];
      assign sl_b[k]  = b_in_c[LO +: W];
      assign sl_ci[k] = cin0_c;
    end else begin : g_next
      assign sl_a[k]  = a_q[k-1][LO +: W];
      assign sl_b[k]  = b_q[k-1][LO +: W];
      assign sl_ci[k] = carry_q[k-1];
    end
    rca_slice #(.W(W)) u_slice (
      .co  (sl_co[k]),
      .sum (sl_sum[k]),
      .a   (sl_a[k]),
      .b   (sl_b[k]),
      .ci  (sl_ci[k])
    );
  end

  // Advance chain, resolved from the output back toward the input.
  always_comb begin
    load_c        = '0;
    drain_c       = '0;
    drain_c[LAST] = valid_q[LAST] & out_ready;
    for (int unsigned k = LAST; k > 0; k--) begin
      load_c[k]    = valid_q[k-1] & (~valid_q[k] | drain_c[k]);
      drain_c[k-1] = load_c[k];
    end
    load_c[0] = in_valid & (~valid_q[0] | drain_c[0]);
  end

  assign in_ready = ~valid_q[0] | drain_c[0];

  always_comb begin
    int unsigned p;
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    p       = 0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      p = (k == 0) ? 32'd0 : k - 32'd1;
      if (load_c[k]) begin
        valid_d[k] = 1'b1;
        carry_d[k] = sl_co[k];
        if (k == 0) begin
          sum_d[k] = '0;
          a_d[k]   = a0;
          b_d[k]   = b_in_c;
        end else begin
          sum_d[k] = sum_q[p];
          a_d[k]   = a_q[p];
          b_d[k]   = b_q[p];
        end
        sum_d[k][k*W +: W] = sl_sum[k];
      end else if (drain_c[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    // Carry into the MSB is recovered from the MSB's own sum bit.
    if (load_c[LAST]) begin
      ovf_d = sl_co[LAST] ^ (sl_a[LAST][W-1] ^ sl_b[LAST][W-1] ^ sl_sum[LAST][W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign co        = carry_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Scoreboard bench for pipe_ripple_adder (N=16, STAGES=4).
module tb_pipe_ripple_adder;

  localparam int unsigned N = 16;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [N-1:0] a0, a1;
  logic         ci, sub;
  logic         out_valid, out_ready;
  logic [N-1:0] sum;
  logic         co, ovf;

  always #5 clk = ~clk;

  pipe_ripple_adder #(.N(N), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a0        (a0),
    .a1        (a1),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [N-1:0] sum;
    logic         co;
    logic         ovf;
    logic [31:0]  cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  int   n_del = 0;
  bit   lat_chk  = 1'b0;
  bit   last_acc = 1'b0;

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic c, input logic s);
    exp_t         e;
    logic [N-1:0] bb;
    logic [N:0]   full;
    bb    = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + (N+1)'(s ? 1'b1 : c);
    e.sum = full[N-1:0];
    e.co  = full[N];
    e.ovf = (a[N-1] == bb[N-1]) && (full[N-1] != a[N-1]);
    e.cyc = 32'(cyc);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then move past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_acc = 1'b0;
    if (out_valid && out_ready) begin
      n_del++;
      if (sb.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("co",  32'(co),  32'(e.co));
        check("ovf", 32'(ovf), 32'(e.ovf));
        if (lat_chk) check("latency", 32'(cyc) - e.cyc, 32'(S));
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(a0, a1, ci, sub));
      n_acc++;
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic c, input logic s);
    int n;
    a0 = a; a1 = b; ci = c; sub = s;
    in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [N-1:0] held;
    bit           have_held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a0 = '0; a1 = '0; ci = 1'b0; sub = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_co",        32'(co),        32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Directed corner cases, back to back.
    lat_chk = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    send(16'h1234, 16'h1111, 1'b1, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 1'b1);
    idle(8);
    check("directed_drained", 32'(sb.size()), 32'd0);

    // Streaming random beats at full rate.
    for (int i = 0; i < 100; i++)
      send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    idle(8);
    check("stream_drained", 32'(sb.size()), 32'd0);

    // Back-pressure: output stalled while the input keeps offering.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    n_acc     = 0;
    have_held = 1'b0;
    held      = '0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a0 = N'($urandom); a1 = N'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      cycle();
      if (out_valid && !have_held) begin
        held      = sum;
        have_held = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("bp_accepts",  32'(n_acc),    32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_sum", 32'(sum),      32'(held));
    out_ready = 1'b1;
    n_del     = 0;
    idle(20);
    check("bp_delivered", 32'(n_del),     32'd4);
    check("bp_drained",   32'(sb.size()), 32'd0);

    // Bubble collapse: two beats separated by a gap close up behind a stall.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    idle(2);
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    idle(6);
    check("bubble_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    n_del     = 0;
    idle(2);
    check("bubble_adjacent", 32'(n_del),     32'd2);
    check("bubble_drained",  32'(sb.size()), 32'd0);

    // Reset mid-stream flushes in-flight beats.
    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    send(16'h0303, 16'h0404, 1'b0, 1'b1);
    send(16'h0505, 16'h0606, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum",       32'(sum),       32'd0);
    check("mid_rst_co",        32'(co),        32'd0);
    check("mid_rst_ovf",       32'(ovf),       32'd0);
    sb.delete();
    idle(1);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    n_del = 0;
    idle(10);
    check("flushed_none", 32'(n_del), 32'd0);

    // Pipeline still works after the flush.
    lat_chk = 1'b1;
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    idle(8);
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
